// File: rtl/lstm_cell_tanh_stage.sv
// LSTM cell-state update stage: c = f*c_prev + i*g, tanh LUT addressing, h = o*tanh(c).
// Two-stage valid/ready pipeline around a per-unit cell-state register file.
module lstm_cell_tanh_stage #(
  parameter int N_CELL     = 16,
  parameter int IDX_W      = 4,
  parameter int ADDR_SHIFT = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  input  logic [7:0]       in_f,
  input  logic [7:0]       in_i,
  input  logic [7:0]       in_o,
  input  logic [7:0]       in_g,
  input  logic             clear_state,
  output logic [7:0]       tanh_addr,
  input  logic [7:0]       tanh_dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [7:0]       out_h,
  output logic [15:0]      out_c
);

  logic signed [15:0] r_c_mem [N_CELL];

  logic               r_s1_valid;
  logic [IDX_W-1:0]   r_s1_idx;
  logic [7:0]         r_s1_o;
  logic signed [15:0] r_s1_c;

  logic               r_s2_valid;
  logic [IDX_W-1:0]   r_out_idx;
  logic [7:0]         r_out_h;
  logic [15:0]        r_out_c;

  logic               w_s2_free;
  logic               w_accept;
  logic               w_idx_ok;
  logic signed [15:0] w_c_prev;
  logic signed [24:0] w_pf_prod;
  logic signed [16:0] w_pi_prod;
  logic signed [17:0] w_pf;
  logic signed [17:0] w_pi;
  logic signed [17:0] w_sum;
  logic signed [15:0] w_c_new;
  logic signed [15:0] w_shift;
  logic signed [7:0]  w_a;
  logic [7:0]         w_t;
  logic signed [16:0] w_h_prod;
  logic [7:0]         w_h;

  // in_ready is a function of pipeline state and out_ready only, never of in_valid.
  assign w_s2_free = !r_s2_valid || out_ready;
  assign in_ready  = !r_s1_valid || w_s2_free;
  assign w_accept  = in_valid && in_ready;

  generate
    if (N_CELL < (1 << IDX_W)) begin : g_idx_check
      assign w_idx_ok = (32'(in_idx) < N_CELL);
    end else begin : g_idx_full
      assign w_idx_ok = 1'b1;
    end
  endgenerate

  // Stage 0: cell-state update, floor shifts and 16-bit saturation.
  assign w_c_prev  = w_idx_ok ? r_c_mem[in_idx] : 16'sd0;
  assign w_pf_prod = $signed({1'b0, in_f}) * w_c_prev;
  assign w_pi_prod = $signed({1'b0, in_i}) * $signed(in_g);
  assign w_pf      = 18'(w_pf_prod >>> 8);
  assign w_pi      = 18'(w_pi_prod >>> 7);
  assign w_sum     = w_pf + w_pi;

  always_comb begin
    w_c_new = w_sum[15:0];
    if (w_sum > 18'sd32767)       w_c_new = 16'sh7FFF;
    else if (w_sum < -18'sd32768) w_c_new = 16'sh8000;
  end

  // Stage 1: quantise cell state to an offset-binary LUT address.
  assign w_shift = r_s1_c >>> ADDR_SHIFT;

  always_comb begin
    w_a = w_shift[7:0];
    if (w_shift > 16'sd127)       w_a = 8'sh7F;
    else if (w_shift < -16'sd128) w_a = 8'sh80;
  end

  assign tanh_addr = r_s1_valid ? {~w_a[7], w_a[6:0]} : 8'h80;
  assign w_t       = tanh_dout ^ 8'h80;
  assign w_h_prod  = $signed({1'b0, r_s1_o}) * $signed(w_t);
  assign w_h       = 8'(w_h_prod >>> 8);

  // NOTE: the cell-state file is reset entry by entry because the block must
  // start from c = 0 for every unit; this keeps it in flops, not a RAM macro.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < N_CELL; k++) r_c_mem[k] <= '0;
    end else if (clear_state) begin
      for (int k = 0; k < N_CELL; k++) r_c_mem[k] <= '0;
    end else if (w_accept && w_idx_ok) begin
      r_c_mem[in_idx] <= w_c_new;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_o     <= '0;
      r_s1_c     <= '0;
      r_s2_valid <= 1'b0;
      r_out_idx  <= '0;
      r_out_h    <= '0;
      r_out_c    <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid <= 1'b1;
        r_s1_idx   <= in_idx;
        r_s1_o     <= in_o;
        r_s1_c     <= w_c_new;
      end else if (w_s2_free) begin
        r_s1_valid <= 1'b0;
      end
      // Outputs load only with real data so they hold while stalled or idle.
      if (w_s2_free) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_out_idx <= r_s1_idx;
          r_out_h   <= w_h;
          r_out_c   <= r_s1_c;
        end
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign out_idx   = r_out_idx;
  assign out_h     = r_out_h;
  assign out_c     = r_out_c;

endmodule

// File: tb/tb_lstm_cell_tanh_stage.sv
// Self-checking bench for lstm_cell_tanh_stage: behavioural LUT, cell-state model
// and an in-order scoreboard of expected {idx, h, c} results.
module tb_lstm_cell_tanh_stage;

  typedef struct packed {
    logic [3:0]  idx;
    logic [7:0]  h;
    logic [15:0] c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_idx;
  logic [7:0]  in_f, in_i, in_o, in_g;
  logic        clear_state;
  logic [7:0]  tanh_addr;
  logic [7:0]  tanh_dout;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic [7:0]  out_h;
  logic [15:0] out_c;

  exp_t        sb_q[$];
  int          model_c[16];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_out    = 0;
  logic [15:0] last_c   = '0;

  lstm_cell_tanh_stage #(.N_CELL(16), .IDX_W(4), .ADDR_SHIFT(3)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_idx      (in_idx),
    .in_f        (in_f),
    .in_i        (in_i),
    .in_o        (in_o),
    .in_g        (in_g),
    .clear_state (clear_state),
    .tanh_addr   (tanh_addr),
    .tanh_dout   (tanh_dout),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_h       (out_h),
    .out_c       (out_c)
  );

  always #5 clk = ~clk;

  // Stand-in tanh table: linear ramp of slope 21/8 clamped to +/-127 (0x88 -> 0x95).
  function automatic logic [7:0] lut_model(input logic [7:0] addr);
    int x, y;
    x = int'($signed(addr ^ 8'h80));
    y = (x * 21) / 8;
    if (y > 127)  y = 127;
    if (y < -127) y = -127;
    return 8'(y) ^ 8'h80;
  endfunction

  assign tanh_dout = lut_model(tanh_addr);

  // Monitor on the falling edge: handshakes seen here complete on the next rising edge.
  always @(negedge clk) begin
    if (!rstn) begin
      sb_q.delete();
      for (int k = 0; k < 16; k++) model_c[k] = 0;
    end else begin
      if (out_valid && out_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          $display("FAIL sb_unexpected: got idx=%0d c=%h h=%h, expected no output", out_idx, out_c, out_h);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if ({out_idx, out_h, out_c} !== {e.idx, e.h, e.c})
            $display("FAIL sb_result: got idx=%0d c=%h h=%h, expected idx=%0d c=%h h=%h",
                     out_idx, out_c, out_h, e.idx, e.c, e.h);
          else
            n_pass++;
        end
        last_c = out_c;
        n_out++;
      end
      if (in_valid && in_ready) begin
        int cp, pf, pi, cn, a, t, h;
        exp_t e;
        cp = model_c[in_idx];
        pf = (int'(in_f) * cp) >>> 8;
        pi = (int'(in_i) * int'($signed(in_g))) >>> 7;
        cn = pf + pi;
        if (cn > 32767)  cn = 32767;
        if (cn < -32768) cn = -32768;
        a = cn >>> 3;
        if (a > 127)  a = 127;
        if (a < -128) a = -128;
        t = int'($signed(lut_model(8'(a + 128)) ^ 8'h80));
        h = (int'(in_o) * t) >>> 8;
        e.idx = in_idx;
        e.h   = 8'(h);
        e.c   = 16'(cn);
        sb_q.push_back(e);
        model_c[in_idx] = cn;
      end
      if (clear_state)
        for (int k = 0; k < 16; k++) model_c[k] = 0;
    end
  end

  task automatic drive(input logic [3:0] idx, input logic [7:0] f, i, o, g);
    bit done = 1'b0;
    in_idx = idx; in_f = f; in_i = i; in_o = o; in_g = g;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL drive_timeout: in_ready stayed %b, expected 1 within 200 cycles", in_ready);
    end
  endtask

  task automatic drive_peek(input logic [3:0] idx, input logic [7:0] f, i, o, g,
                            output logic [7:0] addr);
    drive(idx, f, i, o, g);
    @(negedge clk);
    addr = tanh_addr;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb_q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    n_checks++;
    if (sb_q.size() != 0)
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
    else
      n_pass++;
  endtask

  task automatic test_reset();
    rstn = 1'b0; in_valid = 1'b1; in_idx = 4'd3;
    in_f = 8'hFF; in_i = 8'hFF; in_o = 8'hFF; in_g = 8'h7F;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (tanh_addr !== 8'h80) $display("FAIL rst_tanh_addr: got %h expected 80", tanh_addr); else n_pass++;
    n_checks++;
    if ({out_idx, out_h, out_c} !== 28'h0)
      $display("FAIL rst_outputs: got idx=%0d h=%h c=%h expected all 0", out_idx, out_h, out_c);
    else n_pass++;
    #1 in_valid = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready); else n_pass++;
    @(posedge clk); #1;
    drive(4'd5, 8'hFF, 8'h00, 8'h80, 8'h7F);
    drain();
    n_checks++; if (last_c !== 16'h0000) $display("FAIL rst_cell5: got %h expected 0000", last_c); else n_pass++;
  endtask

  task automatic test_single();
    in_idx = 4'd0; in_f = 8'h80; in_i = 8'h80; in_g = 8'h40; in_o = 8'hFF;
    in_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL single_in_ready: got %b expected 1", in_ready); else n_pass++;
    @(posedge clk); #1;
    in_idx = 4'd0; in_f = 8'h80; in_i = 8'h00; in_g = 8'h00; in_o = 8'hFF;
    @(negedge clk);
    n_checks++; if (tanh_addr !== 8'h88) $display("FAIL single_addr: got %h expected 88", tanh_addr); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL single_early_valid: got %b expected 0", out_valid); else n_pass++;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid: got %b expected 1", out_valid); else n_pass++;
    n_checks++; if (out_c !== 16'h0040) $display("FAIL single_c: got %h expected 0040", out_c); else n_pass++;
    n_checks++; if (out_h !== 8'h14) $display("FAIL single_h: got %h expected 14", out_h); else n_pass++;
    n_checks++; if (out_idx !== 4'd0) $display("FAIL single_idx: got %0d expected 0", out_idx); else n_pass++;
    n_checks++; if (tanh_addr !== 8'h84) $display("FAIL b2b_addr: got %h expected 84", tanh_addr); else n_pass++;
    @(negedge clk);
    n_checks++; if (out_c !== 16'h0020) $display("FAIL b2b_c: got %h expected 0020", out_c); else n_pass++;
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_back_to_back();
    // idx0 holds 0x0020, idx1 holds 0 at this point.
    drive(4'd1, 8'h00, 8'h80, 8'hC0, 8'h40);
    drive(4'd0, 8'h80, 8'h00, 8'hC0, 8'h00);
    drive(4'd1, 8'hFF, 8'h00, 8'hC0, 8'h00);
    drain();
    n_checks++; if (last_c !== 16'h003F) $display("FAIL interleave_c1: got %h expected 003F", last_c); else n_pass++;
    drive(4'd0, 8'hFF, 8'h00, 8'hC0, 8'h00);
    drain();
    n_checks++; if (last_c !== 16'h000F) $display("FAIL interleave_c0: got %h expected 000F", last_c); else n_pass++;
    fork
      begin
        for (int k = 0; k < 30; k++)
          drive(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      end
      begin
        for (int k = 0; k < 120; k++) begin
          @(posedge clk); #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();
  endtask

  task automatic test_saturation();
    logic [7:0] addr;
    for (int k = 0; k < 200; k++) drive(4'd2, 8'hFF, 8'hFF, 8'h40, 8'h7F);
    drain();
    n_checks++; if (last_c !== 16'h7FFF) $display("FAIL sat_pos_c: got %h expected 7FFF", last_c); else n_pass++;
    drive_peek(4'd2, 8'hFF, 8'hFF, 8'h40, 8'h7F, addr);
    n_checks++; if (addr !== 8'hFF) $display("FAIL sat_pos_addr: got %h expected FF", addr); else n_pass++;
    drain();
    n_checks++; if (last_c !== 16'h7FFF) $display("FAIL sat_hold_c: got %h expected 7FFF", last_c); else n_pass++;
    drive_peek(4'd2, 8'h00, 8'hFF, 8'h40, 8'h80, addr);
    n_checks++; if (addr !== 8'h60) $display("FAIL sat_neg_addr: got %h expected 60", addr); else n_pass++;
    drain();
    n_checks++; if (last_c !== 16'hFF01) $display("FAIL sat_neg_c: got %h expected FF01", last_c); else n_pass++;
  endtask

  task automatic test_backpressure();
    int          acc = 0;
    int          n0;
    bit          have_snap = 1'b0;
    bit          moved = 1'b0;
    logic [27:0] snap = '0;
    n0 = n_out;
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = (acc < 4);
      in_idx = 4'(acc + 4); in_f = 8'(acc * 40); in_i = 8'h90; in_o = 8'hA0; in_g = 8'(8'h30 - acc * 24);
      @(negedge clk);
      if (in_valid && in_ready) acc++;
      if (out_valid) begin
        if (!have_snap) begin snap = {out_idx, out_h, out_c}; have_snap = 1'b1; end
        else if ({out_idx, out_h, out_c} !== snap) moved = 1'b1;
      end
      @(posedge clk); #1;
    end
    n_checks++; if (acc != 2) $display("FAIL bp_accepted: got %0d expected 2", acc); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", in_ready); else n_pass++;
    n_checks++; if (!have_snap || moved) $display("FAIL bp_hold: got valid=%b moved=%b expected valid=1 moved=0", have_snap, moved); else n_pass++;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 50 && acc < 4; cyc++) begin
      in_valid = 1'b1;
      in_idx = 4'(acc + 4); in_f = 8'(acc * 40); in_i = 8'h90; in_o = 8'hA0; in_g = 8'(8'h30 - acc * 24);
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain();
    n_checks++; if (n_out - n0 != 4) $display("FAIL bp_count: got %0d results expected 4", n_out - n0); else n_pass++;
  endtask

  task automatic test_clear();
    for (int k = 0; k < 4; k++) drive(4'(k), 8'h00, 8'h80, 8'h70, 8'(8'h20 + k * 16));
    drain();
    // Sample to idx1 sits in stage 1 while the clear fires alongside a new sample to idx3.
    drive(4'd1, 8'h80, 8'h80, 8'hFF, 8'h30);
    clear_state = 1'b1;
    in_idx = 4'd3; in_f = 8'hFF; in_i = 8'h80; in_o = 8'hFF; in_g = 8'h10;
    in_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL clr_in_ready: got %b expected 1", in_ready); else n_pass++;
    @(posedge clk); #1;
    clear_state = 1'b0; in_valid = 1'b0;
    drain();
    for (int k = 0; k < 4; k++) begin
      drive(4'(k), 8'hFF, 8'h00, 8'h80, 8'h55);
      drain();
      n_checks++; if (last_c !== 16'h0000) $display("FAIL clr_cell%0d: got %h expected 0000", k, last_c); else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    drive(4'd6, 8'h00, 8'h80, 8'hFF, 8'h40);
    drive(4'd7, 8'h00, 8'h80, 8'hFF, 8'h50);
    drive(4'd6, 8'hFF, 8'h80, 8'hFF, 8'h40);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b expected 1", out_valid); else n_pass++;
    rstn = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (tanh_addr !== 8'h80) $display("FAIL mid_rst_addr: got %h expected 80", tanh_addr); else n_pass++;
    @(negedge clk);
    @(posedge clk); #1 rstn = 1'b1;
    drive(4'd6, 8'hFF, 8'h00, 8'h80, 8'h00);
    drain();
    n_checks++; if (last_c !== 16'h0000) $display("FAIL mid_cell6: got %h expected 0000", last_c); else n_pass++;
  endtask

  initial begin
    rstn = 1'b0; in_valid = 1'b0; clear_state = 1'b0; out_ready = 1'b1;
    in_idx = '0; in_f = '0; in_i = '0; in_o = '0; in_g = '0;
    @(posedge clk); #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_backpressure();
    test_clear();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded 500000 time units");
    $fatal(1, "watchdog");
  end

endmodule
